sx3_i2c_target_regs: RTL
========================

# sx3_i2c_target_regs

I2C target (responder) for the SX3 I2C bus. It runs on the 48 MHz internal oscillator clock and holds the control and status registers that drive the `*_osc` configuration nets in `topmod`: app enables, socket resets, still capture, image geometry, FPS and line blanking. The SX3 acts as initiator. This block decodes its transactions, ACKs its own address, and serves register reads and writes with an auto-incrementing register pointer.

## Interface
Parameters:
- `DEV_ADDR`, default 7'h18: 7-bit target address.
- `FILT_LEN`, default 3: consecutive identical synchronized samples needed to accept a new SCL/SDA level.
- `ID_VALUE`, default 8'hA5: read-only ID register content.

Ports (name, direction, width, meaning):
- `clk_osc`  in  1  48 MHz system clock.
- `reset_n_HFCLKOUT`  in  1  asynchronous, active-low reset.
- `scl_i`  in  1  raw SCL from pad.
- `sda_i`  in  1  raw SDA from pad.
- `sda_oe_o`  out  1  1 = pull SDA low. Top level drives `sda = oe ? 0 : 1'bz`.
- `pll_lock_i`, `cam_fifo_overflow_i`  in  1 each  status inputs from other domains; double-flopped internally.
- `cam_app_en_osc`, `aud_app_en_osc`, `slfifo_st_vidrst_osc`, `slfifo_st_audrst_osc`  out  1 each  CTRL bits 0..3.
- `still_cap_en_osc`  out  1  one-clock pulse.
- `img_wt_osc`, `img_ht_osc`, `line_blanking_osc`  out  16 each.
- `vid_fps_osc`  out  8.

## Operation
Input conditioning:
- SCL and SDA each pass through a 2-FF synchronizer, then the `FILT_LEN` glitch filter.
- Edge detects are derived from the filtered levels only.
- START: filtered SDA falls while SCL is high. STOP: filtered SDA rises while SCL is high.
- START and STOP are recognised in any state. START goes to ADDR (repeated start included). STOP goes to IDLE and releases SDA.

State machine states: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- Bits are sampled on the SCL rising edge, MSB first.
- SDA drive changes only on the SCL falling edge.
- ADDR: after 8 bits, if `addr[7:1] == DEV_ADDR`, assert ACK and go to ADDR_ACK. Otherwise go to IDLE; a mismatch stays silent until the next START.
- ADDR_ACK with R/W = 0: go to REG. With R/W = 1: load the byte at the pointer and drive it in RDATA.
- REG: the received byte becomes the pointer. ACK, then go to WDATA.
- WDATA: on each byte, commit the write to `reg[ptr]`, ACK, and increment the pointer.
- RDATA: after 8 bits go to RDATA_ACK.
  - The target releases SDA and samples the master's ACK/NACK.
  - ACK: increment the pointer and drive the next byte.
  - NACK: go to IDLE, SDA released.
- The pointer is 8 bits and wraps 0xFF→0x00. A read with no preceding REG phase uses the current pointer.

Register map (reset value in brackets):
- 0x00 CTRL [0x03]: bit0 `cam_app_en`, bit1 `aud_app_en`, bit2 `vidrst`, bit3 `audrst`. Bits 7:4 read 0.
- 0x01 STILL: writing bit0 = 1 fires `still_cap_en_osc`. Reads 0x00.
- 0x02/0x03 IMG_WT lo/hi [0x0780]; 0x04/0x05 IMG_HT [0x0500]; 0x07/0x08 LINE_BLANK [0x0000].
  - Writing the lo byte stages it without changing the output.
  - Writing the hi byte commits {hi, staged lo} atomically.
  - Reads return the committed value.
- 0x06 FPS [0x1E].
- 0x09 STATUS (read-only except W1C): bit0 live `pll_lock`; bit1 sticky overflow, set by `cam_fifo_overflow`, cleared by writing 1 to bit1. If set and clear occur in the same cycle, set wins.
- 0x0A ID: reads `ID_VALUE`. Writes are ignored.
- All other addresses read 0x00; writes to them are ignored but still ACKed.

## Timing
- Filter latency: 2 + `FILT_LEN` clocks from pad to filtered edge. Specified up to 400 kHz SCL (120 clocks per period).
- `sda_oe_o` updates one clock after the filtered SCL falling edge. This gives at least 100 ns hold after SCL falls.
- A write commit, the `still_cap_en_osc` pulse and the ACK assertion all occur in the same clock: the one after the filtered SCL falling edge that ends data bit 8.
- Read data for the next byte is latched at that same falling edge.
- Reset (asynchronous, any time, including mid-transaction):
  - `sda_oe_o` = 0, state IDLE, pointer 0x00.
  - All registers take their reset values; staged lo bytes = 0.
  - `still_cap_en_osc` = 0, sticky overflow = 0.

## Test plan
- Write 0x18<<1|0, reg 0x02, data 0x00, 0x05 → ACK on every byte; `img_wt_osc` reads 0x0780 after the first data byte and becomes 0x0500 after the second.
- Write reg 0x09, repeated START, read 3 bytes ACK/ACK/NACK with `pll_lock_i` = 1 → bytes 0x01, 0xA5, 0x00; SDA released after the NACK.
- Address 0x19 → no ACK, no register change; bus ignored until the next START.
- Write reg 0x01, data 0x01 → exactly one `still_cap_en_osc` pulse of one clock; a subsequent read of 0x01 returns 0x00.
- Pulse `cam_fifo_overflow_i` → STATUS bit1 = 1; write 0x02 to 0x09 → bit1 = 0. Raise overflow in the same clock as the clear → bit1 stays 1.
- Assert reset midway through a WDATA byte → `sda_oe_o` goes low at once; CTRL returns to 0x03; the next transaction decodes normally. Also inject a 2-clock SCL glitch → no bit is counted.

Source files
------------

// File: rtl/sx3_i2c_target_regs.sv
// I2C target holding the SX3 control/status registers that feed the *_osc nets.
// Ports:
//   clk_osc, reset_n_HFCLKOUT        48 MHz clock, async active-low reset
//   scl_i, sda_i                     raw pad levels
//   sda_oe_o                         1 = pull SDA low
//   pll_lock_i, cam_fifo_overflow_i  asynchronous status inputs
//   cam_app_en_osc .. slfifo_st_audrst_osc  CTRL bits 0..3
//   still_cap_en_osc                 one-clock still capture pulse
//   img_wt_osc, img_ht_osc, line_blanking_osc, vid_fps_osc  image configuration
module sx3_i2c_target_regs #(
    parameter logic [6:0]  DEV_ADDR = 7'h18,
    parameter int unsigned FILT_LEN = 3,
    parameter logic [7:0]  ID_VALUE = 8'hA5
) (
    input  logic        clk_osc,
    input  logic        reset_n_HFCLKOUT,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe_o,
    input  logic        pll_lock_i,
    input  logic        cam_fifo_overflow_i,
    output logic        cam_app_en_osc,
    output logic        aud_app_en_osc,
    output logic        slfifo_st_vidrst_osc,
    output logic        slfifo_st_audrst_osc,
    output logic        still_cap_en_osc,
    output logic [15:0] img_wt_osc,
    output logic [15:0] img_ht_osc,
    output logic [15:0] line_blanking_osc,
    output logic [7:0]  vid_fps_osc
);

    localparam int unsigned CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_REG, ST_REG_ACK,
        ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_ACK
    } state_t;

    // index 0 = SCL, index 1 = SDA
    logic [1:0]            meta, sync, filt, filt_d;
    logic [1:0][CNT_W-1:0] cnt;
    logic [1:0]            pll_ff, ovf_ff;

    state_t      state, state_nxt;
    logic [3:0]  bit_cnt;
    logic [7:0]  shift, ptr, rd_byte, rd_shift, rd_addr, rd_val;
    logic        rw, mack, oe_nxt;
    logic        cnt_clr, rw_load, ptr_load, ptr_inc, wr_en, rd_load, drv_start, drv_shift;

    logic [3:0]  ctrl;
    logic [7:0]  wt_lo, ht_lo, lb_lo, fps;
    logic [15:0] img_wt, img_ht, lb;
    logic        ovf;

    logic scl_rise, scl_fall, sda_rise, sda_fall, start_c, stop_c, byte_done, counting;

    // Synchronizers and glitch filters; a new level needs FILT_LEN identical samples.
    always_ff @(posedge clk_osc or negedge reset_n_HFCLKOUT) begin
        if (!reset_n_HFCLKOUT) begin
            meta   <= 2'b11;
            sync   <= 2'b11;
            filt   <= 2'b11;
            filt_d <= 2'b11;
            cnt    <= '0;
            pll_ff <= 2'b00;
            ovf_ff <= 2'b00;
        end else begin
            meta   <= {sda_i, scl_i};
            sync   <= meta;
            filt_d <= filt;
            pll_ff <= {pll_ff[0], pll_lock_i};
            ovf_ff <= {ovf_ff[0], cam_fifo_overflow_i};
            for (int i = 0; i < 2; i++) begin
                if (sync[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_W'(FILT_LEN - 1)) begin
                    filt[i] <= sync[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign scl_rise  = filt[0] & ~filt_d[0];
    assign scl_fall  = ~filt[0] & filt_d[0];
    assign sda_rise  = filt[1] & ~filt_d[1];
    assign sda_fall  = ~filt[1] & filt_d[1];
    assign start_c   = sda_fall & filt[0];
    assign stop_c    = sda_rise & filt[0];
    assign byte_done = (bit_cnt == 4'd8);
    assign counting  = (state == ST_ADDR) || (state == ST_REG) ||
                       (state == ST_WDATA) || (state == ST_RDATA);

    // FSM state register
    always_ff @(posedge clk_osc or negedge reset_n_HFCLKOUT) begin
        if (!reset_n_HFCLKOUT) state <= ST_IDLE;
        else                   state <= state_nxt;
    end

    // Next state, SDA drive and datapath strobes; SDA only moves on SCL falling edges.
    always_comb begin
        state_nxt = state;
        oe_nxt    = sda_oe_o;
        cnt_clr   = 1'b0;
        rw_load   = 1'b0;
        ptr_load  = 1'b0;
        ptr_inc   = 1'b0;
        wr_en     = 1'b0;
        rd_load   = 1'b0;
        rd_addr   = ptr;
        drv_start = 1'b0;
        drv_shift = 1'b0;
        if (stop_c) begin
            state_nxt = ST_IDLE;
            oe_nxt    = 1'b0;
        end else if (start_c) begin
            state_nxt = ST_ADDR;
            oe_nxt    = 1'b0;
            cnt_clr   = 1'b1;
        end else if (scl_fall) begin
            case (state)
                ST_ADDR: if (byte_done) begin
                    if (shift[7:1] == DEV_ADDR) begin
                        state_nxt = ST_ADDR_ACK;
                        oe_nxt    = 1'b1;
                        rw_load   = 1'b1;
                        rd_load   = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_ADDR_ACK: begin
                    cnt_clr = 1'b1;
                    if (rw) begin
                        state_nxt = ST_RDATA;
                        oe_nxt    = ~rd_byte[7];
                        drv_start = 1'b1;
                    end else begin
                        state_nxt = ST_REG;
                        oe_nxt    = 1'b0;
                    end
                end
                ST_REG: if (byte_done) begin
                    state_nxt = ST_REG_ACK;
                    oe_nxt    = 1'b1;
                    ptr_load  = 1'b1;
                end
                ST_REG_ACK, ST_WDATA_ACK: begin
                    state_nxt = ST_WDATA;
                    oe_nxt    = 1'b0;
                    cnt_clr   = 1'b1;
                end
                ST_WDATA: if (byte_done) begin
                    state_nxt = ST_WDATA_ACK;
                    oe_nxt    = 1'b1;
                    wr_en     = 1'b1;
                    ptr_inc   = 1'b1;
                end
                ST_RDATA: begin
                    if (byte_done) begin
                        // release for the master's ACK and prefetch the next byte
                        state_nxt = ST_RDATA_ACK;
                        oe_nxt    = 1'b0;
                        rd_load   = 1'b1;
                        rd_addr   = ptr + 8'd1;
                    end else begin
                        oe_nxt    = ~rd_shift[7];
                        drv_shift = 1'b1;
                    end
                end
                ST_RDATA_ACK: begin
                    if (mack) begin
                        state_nxt = ST_RDATA;
                        ptr_inc   = 1'b1;
                        cnt_clr   = 1'b1;
                        oe_nxt    = ~rd_byte[7];
                        drv_start = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                        oe_nxt    = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bit counter, shifters, pointer and SDA drive
    always_ff @(posedge clk_osc or negedge reset_n_HFCLKOUT) begin
        if (!reset_n_HFCLKOUT) begin
            bit_cnt  <= 4'd0;
            shift    <= 8'h00;
            rw       <= 1'b0;
            mack     <= 1'b0;
            ptr      <= 8'h00;
            rd_byte  <= 8'h00;
            rd_shift <= 8'h00;
            sda_oe_o <= 1'b0;
        end else begin
            sda_oe_o <= oe_nxt;
            if (cnt_clr) begin
                bit_cnt <= 4'd0;
            end else if (scl_rise && counting && !byte_done) begin
                bit_cnt <= bit_cnt + 4'd1;
                shift   <= {shift[6:0], filt[1]};
            end
            if (scl_rise && state == ST_RDATA_ACK) mack <= ~filt[1];
            if (rw_load) rw <= shift[0];
            if (ptr_load)     ptr <= shift;
            else if (ptr_inc) ptr <= ptr + 8'd1;
            if (rd_load) rd_byte <= rd_val;
            if (drv_start)      rd_shift <= {rd_byte[6:0], 1'b0};
            else if (drv_shift) rd_shift <= {rd_shift[6:0], 1'b0};
        end
    end

    // Register file; 16-bit values commit on the hi byte together with the staged lo byte
    always_ff @(posedge clk_osc or negedge reset_n_HFCLKOUT) begin
        if (!reset_n_HFCLKOUT) begin
            ctrl   <= 4'h3;
            wt_lo  <= 8'h00;
            ht_lo  <= 8'h00;
            lb_lo  <= 8'h00;
            img_wt <= 16'h0780;
            img_ht <= 16'h0500;
            lb     <= 16'h0000;
            fps    <= 8'h1E;
            ovf    <= 1'b0;
            still_cap_en_osc <= 1'b0;
        end else begin
            still_cap_en_osc <= wr_en && (ptr == 8'h01) && shift[0];
            if (wr_en) begin
                case (ptr)
                    8'h00: ctrl   <= shift[3:0];
                    8'h02: wt_lo  <= shift;
                    8'h03: img_wt <= {shift, wt_lo};
                    8'h04: ht_lo  <= shift;
                    8'h05: img_ht <= {shift, ht_lo};
                    8'h06: fps    <= shift;
                    8'h07: lb_lo  <= shift;
                    8'h08: lb     <= {shift, lb_lo};
                    default: ;
                endcase
            end
            // set has priority over the write-one-to-clear
            if (ovf_ff[1])                                     ovf <= 1'b1;
            else if (wr_en && (ptr == 8'h09) && shift[1])      ovf <= 1'b0;
        end
    end

    // Read mux
    always_comb begin
        rd_val = 8'h00;
        case (rd_addr)
            8'h00: rd_val = {4'h0, ctrl};
            8'h02: rd_val = img_wt[7:0];
            8'h03: rd_val = img_wt[15:8];
            8'h04: rd_val = img_ht[7:0];
            8'h05: rd_val = img_ht[15:8];
            8'h06: rd_val = fps;
            8'h07: rd_val = lb[7:0];
            8'h08: rd_val = lb[15:8];
            8'h09: rd_val = {6'b0, ovf, pll_ff[1]};
            8'h0A: rd_val = ID_VALUE;
            default: rd_val = 8'h00;
        endcase
    end

    assign cam_app_en_osc       = ctrl[0];
    assign aud_app_en_osc       = ctrl[1];
    assign slfifo_st_vidrst_osc = ctrl[2];
    assign slfifo_st_audrst_osc = ctrl[3];
    assign img_wt_osc           = img_wt;
    assign img_ht_osc           = img_ht;
    assign line_blanking_osc    = lb;
    assign vid_fps_osc          = fps;

endmodule
